mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bundle: fetch port, data port and the single memory port.
// slave = arbiter side, master = requesters plus memory (the bench side).
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              err;
    logic              busy;

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_ack,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ack,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output err, busy
    );

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_ack,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  err, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one shared memory port; data wins unless fetch is starved, busy cycles are time-limited.
// Grant -> mem_req next cycle, acks combinational with mem_ack; requesters are backpressured by holding req until ack.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 15
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t            r_state;
    logic [SW-1:0]     r_starve_cnt;
    logic [TW-1:0]     r_tmo_cnt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    state_t            w_next_state;
    logic              w_busy;
    logic              w_tmo_hit;
    logic              w_done;
    logic              w_cand_i;
    logic              w_cand_d;
    logic              w_starved;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_live;
    logic              w_i_ack;
    logic              w_d_ack;
    logic              w_err;
    logic [DATA_W-1:0] w_i_rdata;
    logic [DATA_W-1:0] w_d_rdata;

    // The port being acked this cycle is excluded: its req is still the old, already-served level.
    always_comb begin
        w_busy       = (r_state != IDLE);
        w_tmo_hit    = w_busy && !bus.mem_ack && (r_tmo_cnt == TW'(TIMEOUT - 1));
        w_done       = w_busy && (bus.mem_ack || w_tmo_hit);
        w_cand_i     = bus.i_req && ((r_state == IDLE) || ((r_state == BUSY_D) && w_done));
        w_cand_d     = bus.d_req && ((r_state == IDLE) || ((r_state == BUSY_I) && w_done));
        w_starved    = (r_starve_cnt == SW'(STARVE_LIMIT));
        w_grant_i    = w_cand_i && (!w_cand_d || w_starved);
        w_grant_d    = w_cand_d && !w_grant_i;
        w_next_state = r_state;
        if (w_grant_i) begin
            w_next_state = BUSY_I;
        end else if (w_grant_d) begin
            w_next_state = BUSY_D;
        end else if (w_done) begin
            w_next_state = IDLE;
        end
    end

    // Reset in flight must swallow any ack that memory happens to return in that cycle.
    always_comb begin
        w_live    = !reset;
        w_i_ack   = w_live && (r_state == BUSY_I) && w_done;
        w_d_ack   = w_live && (r_state == BUSY_D) && w_done;
        w_err     = w_live && w_tmo_hit;
        w_i_rdata = '0;
        w_d_rdata = '0;
        if (w_live && (r_state == BUSY_I) && bus.mem_ack) begin
            w_i_rdata = bus.mem_rdata;
        end
        if (w_live && (r_state == BUSY_D) && bus.mem_ack && !r_mem_we) begin
            w_d_rdata = bus.mem_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_tmo_cnt    <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_i) begin
                r_starve_cnt <= '0;
                r_tmo_cnt    <= '0;
                r_mem_req    <= 1'b1;
                r_mem_we     <= 1'b0;
                r_mem_addr   <= bus.i_addr;
                r_mem_wdata  <= '0;
            end else if (w_grant_d) begin
                if (!bus.i_req) begin
                    r_starve_cnt <= '0;
                end else if (!w_starved) begin
                    r_starve_cnt <= r_starve_cnt + SW'(1);
                end
                r_tmo_cnt   <= '0;
                r_mem_req   <= 1'b1;
                r_mem_we    <= bus.d_we;
                r_mem_addr  <= bus.d_addr;
                r_mem_wdata <= bus.d_wdata;
            end else if (w_done) begin
                r_mem_req <= 1'b0;
            end else if (w_busy) begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
        end
    end

    assign bus.i_ack     = w_i_ack;
    assign bus.d_ack     = w_d_ack;
    assign bus.i_rdata   = w_i_rdata;
    assign bus.d_rdata   = w_d_rdata;
    assign bus.err       = w_err;
    assign bus.busy      = w_busy;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic,
// all outputs compared every cycle against a transaction-level owner model.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 3;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: who owns the memory and for how long ----------------
    bit          chk_en = 1'b0;
    int          m_owner = 0;     // 0 none, 1 fetch, 2 data
    int          m_wait  = 0;     // busy cycles already spent without completion
    int          m_starve = 0;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    int          grant_log[$];
    bit          md_done, md_to, mg_i, mg_d;

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_req", bus.mem_req, (m_owner != 0));
            check("busy", bus.busy, (m_owner != 0));
            if (rst) begin
                check("i_ack_in_reset", bus.i_ack, 0);
                check("d_ack_in_reset", bus.d_ack, 0);
                check("err_in_reset", bus.err, 0);
                check("i_rdata_in_reset", bus.i_rdata, 0);
                check("d_rdata_in_reset", bus.d_rdata, 0);
                m_owner  = 0;
                m_wait   = 0;
                m_starve = 0;
            end else begin
                if (m_owner != 0) begin
                    check("mem_we", bus.mem_we, m_we);
                    check("mem_addr", bus.mem_addr, m_addr);
                    if (m_we) check("mem_wdata", bus.mem_wdata, m_wdata);
                end
                md_to   = (m_owner != 0) && !bus.mem_ack && (m_wait + 1 == TO);
                md_done = (m_owner != 0) && (bus.mem_ack || md_to);
                check("i_ack", bus.i_ack, (m_owner == 1) && md_done);
                check("d_ack", bus.d_ack, (m_owner == 2) && md_done);
                check("err", bus.err, md_to);
                check("i_rdata", bus.i_rdata, (m_owner == 1 && bus.mem_ack) ? bus.mem_rdata : 32'h0);
                check("d_rdata", bus.d_rdata,
                      (m_owner == 2 && bus.mem_ack && !m_we) ? bus.mem_rdata : 32'h0);
                mg_i = 1'b0;
                mg_d = 1'b0;
                if (m_owner == 0) begin
                    mg_d = bus.d_req && !(bus.i_req && m_starve == SL);
                    mg_i = bus.i_req && !mg_d;
                end else if (md_done) begin
                    mg_i = (m_owner == 2) && bus.i_req;
                    mg_d = (m_owner == 1) && bus.d_req;
                end
                if (mg_d) m_starve = bus.i_req ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
                if (mg_i) m_starve = 0;
                if (mg_i || mg_d) begin
                    m_owner = mg_i ? 1 : 2;
                    m_wait  = 0;
                    m_we    = mg_d ? bus.d_we : 1'b0;
                    m_addr  = mg_i ? bus.i_addr : bus.d_addr;
                    m_wdata = bus.d_wdata;
                    grant_log.push_back(m_owner);
                end else if (md_done) begin
                    m_owner = 0;
                end else if (m_owner != 0) begin
                    m_wait++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_i();
        bus.i_req  = 1'b1;
        bus.i_addr = $urandom;
    endtask

    task automatic new_d();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
    endtask

    int tcyc, log_base, lat_cnt, lat_tgt;
    logic prev_ai, prev_ad, t_err;
    logic [31:0] t_rd;

    initial begin
        rst = 1'b1;
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_ack = 0;
        step();
        chk_en = 1'b1;
        step();
        @(negedge clk);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_acks", {bus.i_ack, bus.d_ack, bus.err}, 0);
        step();
        rst = 1'b0;

        // single fetch read, one-cycle memory
        bus.i_req = 1; bus.i_addr = 32'h40;
        step();
        bus.mem_ack = 1; bus.mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("rd_mem_req", bus.mem_req, 1);
        check("rd_mem_addr", bus.mem_addr, 32'h40);
        check("rd_i_ack", bus.i_ack, 1);
        check("rd_i_rdata", bus.i_rdata, 32'hDEADBEEF);
        step();
        bus.i_req = 0; bus.mem_ack = 0;
        @(negedge clk);
        check("rd_busy_after", bus.busy, 0);
        step();

        // simultaneous requests: data write first, fetch handed over with no idle cycle
        bus.i_req = 1; bus.i_addr = 32'h100;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h80; bus.d_wdata = 32'h1234;
        step();
        @(negedge clk);
        check("sim_mem_we", bus.mem_we, 1);
        check("sim_mem_addr", bus.mem_addr, 32'h80);
        check("sim_mem_wdata", bus.mem_wdata, 32'h1234);
        step();
        bus.mem_ack = 1; bus.mem_rdata = 32'h5555AAAA;
        @(negedge clk);
        check("sim_d_ack", bus.d_ack, 1);
        check("sim_i_ack_low", bus.i_ack, 0);
        check("sim_d_rdata_write", bus.d_rdata, 0);
        step();
        bus.d_req = 0; bus.mem_ack = 0;
        @(negedge clk);
        check("sim_handoff_req", bus.mem_req, 1);
        check("sim_handoff_addr", bus.mem_addr, 32'h100);
        check("sim_handoff_we", bus.mem_we, 0);
        step();
        bus.mem_ack = 1;
        @(negedge clk);
        check("sim_i_ack", bus.i_ack, 1);
        step();
        bus.i_req = 0; bus.mem_ack = 0;
        step();

        // timeout on a data read that memory never answers
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
        step();
        tcyc = 0; t_err = 0; t_rd = 32'hFFFFFFFF;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.d_ack) begin
                tcyc = k; t_err = bus.err; t_rd = bus.d_rdata;
                break;
            end
            step();
        end
        check("tmo_cycle", tcyc, TO);
        check("tmo_err", t_err, 1);
        check("tmo_d_rdata", t_rd, 0);
        step();
        bus.d_req = 0;
        @(negedge clk);
        check("tmo_mem_req_drop", bus.mem_req, 0);
        step();

        // reset in the middle of a data transaction
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
        step();
        step();
        step();
        rst = 1; bus.mem_ack = 1; bus.mem_rdata = 32'h0BAD0BAD;
        @(negedge clk);
        check("rstmid_no_d_ack", bus.d_ack, 0);
        check("rstmid_no_rdata", bus.d_rdata, 0);
        step();
        rst = 0; bus.mem_ack = 0; bus.d_req = 0;
        bus.i_req = 1; bus.i_addr = 32'h400;
        @(negedge clk);
        check("rstmid_idle", bus.busy, 0);
        check("rstmid_mem_req", bus.mem_req, 0);
        step();
        @(negedge clk);
        check("rstmid_new_grant", bus.mem_addr, 32'h400);
        step();
        bus.mem_ack = 1;
        @(negedge clk);
        check("rstmid_i_ack", bus.i_ack, 1);
        step();
        bus.i_req = 0; bus.mem_ack = 0;
        step();

        // both ports held continuously: the acked port always hands off to the other
        log_base = grant_log.size();
        bus.i_req = 1; bus.i_addr = 32'h600;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h700;
        for (int k = 0; k < 8; k++) begin
            bus.mem_ack = bus.mem_req;
            bus.mem_rdata = $urandom;
            step();
        end
        bus.i_req = 0; bus.d_req = 0;
        bus.mem_ack = bus.mem_req;
        step();
        bus.mem_ack = 0;
        step();
        check("order_g0_data", grant_log[log_base], 2);
        check("order_g1_fetch", grant_log[log_base + 1], 1);
        check("order_g2_data", grant_log[log_base + 2], 2);
        check("order_g3_fetch", grant_log[log_base + 3], 1);

        // stale data request held one cycle past its ack
        step();
        log_base = grant_log.size();
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h500;
        step();
        bus.mem_ack = 1;
        @(negedge clk);
        check("stale_first_ack", bus.d_ack, 1);
        step();
        bus.mem_ack = 0;
        @(negedge clk);
        check("stale_no_handoff", bus.busy, 0);
        step();
        bus.d_req = 0; bus.mem_ack = 1;
        @(negedge clk);
        check("stale_regrant_from_idle", bus.mem_req, 1);
        step();
        bus.mem_ack = 0;
        step();
        check("stale_grant_count", grant_log.size() - log_base, 2);

        // random traffic
        prev_ai = 0; prev_ad = 0; lat_cnt = 0; lat_tgt = 1;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            if (prev_ai) begin
                if ($urandom_range(0, 1) == 1) new_i(); else bus.i_req = 0;
            end else if (!bus.i_req && $urandom_range(0, 2) == 0) begin
                new_i();
            end
            if (prev_ad) begin
                if ($urandom_range(0, 1) == 1) new_d(); else bus.d_req = 0;
            end else if (!bus.d_req && $urandom_range(0, 2) == 0) begin
                new_d();
            end
            if (prev_ai || prev_ad || !bus.mem_req) lat_cnt = 0;
            if (bus.mem_req) begin
                if (lat_cnt == 0) begin
                    case ($urandom_range(0, 9))
                        0:       lat_tgt = 20;
                        1:       lat_tgt = TO;
                        default: lat_tgt = $urandom_range(1, 4);
                    endcase
                end
                lat_cnt++;
                bus.mem_ack = (lat_cnt == lat_tgt);
            end else begin
                bus.mem_ack = ($urandom_range(0, 7) == 0);
            end
            bus.mem_rdata = $urandom;
            @(negedge clk);
            prev_ai = bus.i_ack;
            prev_ad = bus.d_ack;
            check("acks_exclusive", bus.i_ack & bus.d_ack, 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
